// File: rtl/range_stats_pkg.sv
// Shared types for range_stats: statistic selector and frame state.
package range_stats_pkg;

    localparam int unsigned MODE_W = 2;

    // Statistic reported at the end of a frame; encoding matches the mode pins.
    typedef enum logic [MODE_W-1:0] {
        MODE_RANGE = 2'd0,
        MODE_MIN   = 2'd1,
        MODE_MAX   = 2'd2,
        MODE_COUNT = 2'd3
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/range_stats_acc.sv
// Running min/max/count accumulator for range_stats.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   init_i                load data_i as the first sample of a frame
//   update_i              fold data_i into the running statistics
//   data_i                unsigned sample
//   min_d_o/max_d_o/count_d_o  next-state statistics (combinational), so the
//                         parent can capture a result on the same edge the
//                         last sample is folded in
module range_stats_acc
    import range_stats_pkg::*;
#(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             init_i,
    input  logic             update_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] min_d_o,
    output logic [WIDTH-1:0] max_d_o,
    output logic [WIDTH-1:0] count_d_o
);

    localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] count_q, count_d;

    // Next-state statistics; init takes priority over update.
    always_comb begin
        min_d   = min_q;
        max_d   = max_q;
        count_d = count_q;
        if (init_i) begin
            min_d   = data_i;
            max_d   = data_i;
            count_d = WIDTH'(1);
        end else if (update_i) begin
            if (data_i < min_q) min_d = data_i;
            if (data_i > max_q) max_d = data_i;
            // Count saturates at all-ones rather than wrapping.
            if (count_q != COUNT_MAX) count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            min_q   <= '0;
            max_q   <= '0;
            count_q <= '0;
        end else begin
            min_q   <= min_d;
            max_q   <= max_d;
            count_q <= count_d;
        end
    end

    assign min_d_o   = min_d;
    assign max_d_o   = max_d;
    assign count_d_o = count_d;

endmodule

// File: rtl/range_stats.sv
// Framed min/max/range/count statistics with a registered, mode-selected result.
// Ports:
//   clock, reset     clock, synchronous active-high reset
//   data_in          unsigned sample, valid each cycle of an open frame
//   go, finish       frame start / frame end (same-cycle sample included)
//   mode             statistic select, latched on an accepted go
//   result           selected statistic of the last completed frame
//   result_valid     one-cycle pulse when result is updated
//   busy             frame open
//   error            sticky protocol-error flag, cleared by an accepted go
module range_stats
    import range_stats_pkg::*;
#(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             go,
    input  logic             finish,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic             error
);

    state_t           state_q;
    mode_t            mode_q;
    logic [WIDTH-1:0] result_q;
    logic             result_valid_q;
    logic             busy_q;
    logic             error_q;

    logic             go_accept_c;
    logic             run_c;
    mode_t            mode_eff_c;
    logic [WIDTH-1:0] stat_c;
    logic [WIDTH-1:0] min_n, max_n, count_n;

    assign go_accept_c = (state_q == ST_IDLE) && go;
    assign run_c       = (state_q == ST_RUN);

    // On a single-sample frame the mode register has not been loaded yet.
    assign mode_eff_c  = go_accept_c ? mode_t'(mode) : mode_q;

    range_stats_acc #(
        .WIDTH (WIDTH)
    ) u_acc (
        .clk_i     (clock),
        .rst_i     (reset),
        .init_i    (go_accept_c),
        .update_i  (run_c),
        .data_i    (data_in),
        .min_d_o   (min_n),
        .max_d_o   (max_n),
        .count_d_o (count_n)
    );

    // Result mux over the post-sample statistics; max >= min so range cannot underflow.
    always_comb begin
        stat_c = '0;
        case (mode_eff_c)
            MODE_RANGE: stat_c = max_n - min_n;
            MODE_MIN:   stat_c = min_n;
            MODE_MAX:   stat_c = max_n;
            MODE_COUNT: stat_c = count_n;
            default:    stat_c = '0;
        endcase
    end

    // Frame FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            mode_q         <= MODE_RANGE;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        mode_q  <= mode_t'(mode);
                        error_q <= 1'b0;
                        if (finish) begin
                            result_q       <= stat_c;
                            result_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end else if (finish) begin
                        error_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // A go inside a frame is flagged but otherwise ignored.
                    if (go) error_q <= 1'b1;
                    if (finish) begin
                        result_q       <= stat_c;
                        result_valid_q <= 1'b1;
                        state_q        <= ST_IDLE;
                        busy_q         <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign error        = error_q;

endmodule

// File: tb/tb_range_stats.sv
// Testbench for range_stats: a WIDTH=10 and a WIDTH=4 instance share control
// inputs; both are compared every cycle against a frame-level reference model.
module tb_range_stats;

    localparam int unsigned W0 = 10;
    localparam int unsigned W1 = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          go;
    logic          finish;
    logic [1:0]    mode;
    logic [W0-1:0] data0;
    logic [W1-1:0] data1;

    logic [W0-1:0] result0;
    logic          result_valid0, busy0, error0;
    logic [W1-1:0] result1;
    logic          result_valid1, busy1, error1;

    always #5 clock = ~clock;

    range_stats #(.WIDTH(W0)) dut0 (
        .clock        (clock),
        .reset        (reset),
        .data_in      (data0),
        .go           (go),
        .finish       (finish),
        .mode         (mode),
        .result       (result0),
        .result_valid (result_valid0),
        .busy         (busy0),
        .error        (error0)
    );

    range_stats #(.WIDTH(W1)) dut1 (
        .clock        (clock),
        .reset        (reset),
        .data_in      (data1),
        .go           (go),
        .finish       (finish),
        .mode         (mode),
        .result       (result1),
        .result_valid (result_valid1),
        .busy         (busy1),
        .error        (error1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: frame samples kept in a queue, stats computed at finish.
    int samp[$];
    bit m_in_frame = 0;
    bit m_err      = 0;
    bit m_valid    = 0;
    int m_mode     = 0;
    int m_res0     = 0;
    int m_res1     = 0;

    function automatic int frame_stat(input int md, input int mask);
        int mn, mx, cnt;
        mn = mask;
        mx = 0;
        foreach (samp[i]) begin
            if ((samp[i] & mask) < mn) mn = samp[i] & mask;
            if ((samp[i] & mask) > mx) mx = samp[i] & mask;
        end
        cnt = (samp.size() > mask) ? mask : samp.size();
        case (md)
            0: return mx - mn;
            1: return mn;
            2: return mx;
            default: return cnt;
        endcase
    endfunction

    task automatic model_edge(input bit r, input bit g, input bit f, input int m, input int d);
        m_valid = 0;
        if (r) begin
            m_in_frame = 0;
            samp.delete();
            m_err  = 0;
            m_mode = 0;
            m_res0 = 0;
            m_res1 = 0;
        end else if (!m_in_frame) begin
            if (g) begin
                samp.delete();
                samp.push_back(d);
                m_mode = m;
                m_err  = 0;
                if (f) begin
                    m_res0  = frame_stat(m_mode, (1 << W0) - 1);
                    m_res1  = frame_stat(m_mode, (1 << W1) - 1);
                    m_valid = 1;
                end else begin
                    m_in_frame = 1;
                end
            end else if (f) begin
                m_err = 1;
            end
        end else begin
            samp.push_back(d);
            if (g) m_err = 1;
            if (f) begin
                m_res0     = frame_stat(m_mode, (1 << W0) - 1);
                m_res1     = frame_stat(m_mode, (1 << W1) - 1);
                m_valid    = 1;
                m_in_frame = 0;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive, update model at the edge, compare both DUTs #1 later.
    task automatic step(input bit r, input bit g, input bit f, input int m, input int d);
        reset  = r;
        go     = g;
        finish = f;
        mode   = 2'(m);
        data0  = W0'(d);
        data1  = W1'(d);
        @(posedge clock);
        model_edge(r, g, f, m, d);
        #1;
        chk("w10_result", int'(result0), m_res0);
        chk("w10_valid",  int'(result_valid0), int'(m_valid));
        chk("w10_busy",   int'(busy0), int'(m_in_frame));
        chk("w10_error",  int'(error0), int'(m_err));
        chk("w4_result",  int'(result1), m_res1);
        chk("w4_valid",   int'(result_valid1), int'(m_valid));
        chk("w4_busy",    int'(busy1), int'(m_in_frame));
        chk("w4_error",   int'(error1), int'(m_err));
    endtask

    typedef struct {
        bit r, g, f;
        int m, d;
        int res;
        bit v, b, e;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit r, input bit g, input bit f, input int m, input int d,
                                input int res, input bit v, input bit b, input bit e);
        vec_t t;
        t.r = r; t.g = g; t.f = f; t.m = m; t.d = d;
        t.res = res; t.v = v; t.b = b; t.e = e;
        return t;
    endfunction

    initial begin
        reset = 1'b1; go = 1'b0; finish = 1'b0; mode = 2'd0; data0 = '0; data1 = '0;

        // Hand-derived WIDTH=10 expectations: {r,g,f,mode,data, result,valid,busy,error}
        tbl.push_back(mk(1,0,0,0,   0,    0,0,0,0));
        tbl.push_back(mk(0,1,0,0, 100,    0,0,1,0));  // RANGE frame
        tbl.push_back(mk(0,0,0,0,  37,    0,0,1,0));
        tbl.push_back(mk(0,0,0,0, 512,    0,0,1,0));
        tbl.push_back(mk(0,0,1,0, 200,  475,1,0,0));
        tbl.push_back(mk(0,0,0,0,   0,  475,0,0,0));
        tbl.push_back(mk(0,1,0,1, 100,  475,0,1,0));  // MIN latched, mode toggled mid-frame
        tbl.push_back(mk(0,0,0,2,  37,  475,0,1,0));
        tbl.push_back(mk(0,0,0,3, 512,  475,0,1,0));
        tbl.push_back(mk(0,0,1,0, 200,   37,1,0,0));
        tbl.push_back(mk(0,1,0,2, 100,   37,0,1,0));  // MAX
        tbl.push_back(mk(0,0,0,0,  37,   37,0,1,0));
        tbl.push_back(mk(0,0,0,1, 512,   37,0,1,0));
        tbl.push_back(mk(0,0,1,3, 200,  512,1,0,0));
        tbl.push_back(mk(0,1,0,3, 100,  512,0,1,0));  // COUNT
        tbl.push_back(mk(0,0,0,0,  37,  512,0,1,0));
        tbl.push_back(mk(0,0,0,1, 512,  512,0,1,0));
        tbl.push_back(mk(0,0,1,2, 200,    4,1,0,0));
        tbl.push_back(mk(0,1,1,0,1023,    0,1,0,0));  // single-sample RANGE
        tbl.push_back(mk(0,1,1,2,1023, 1023,1,0,0));  // single-sample MAX
        tbl.push_back(mk(0,0,1,0,   5, 1023,0,0,1));  // finish in IDLE
        tbl.push_back(mk(0,0,0,0,   0, 1023,0,0,1));
        tbl.push_back(mk(0,1,0,0, 300, 1023,0,1,0));  // accepted go clears error
        tbl.push_back(mk(0,1,0,3,  50, 1023,0,1,1));  // go during RUN
        tbl.push_back(mk(0,0,1,0, 600,  550,1,0,1));
        tbl.push_back(mk(0,0,0,0,   0,  550,0,0,1));
        tbl.push_back(mk(0,1,0,0,  10,  550,0,1,0));
        tbl.push_back(mk(0,0,0,0,  20,  550,0,1,0));
        tbl.push_back(mk(1,0,0,0,  30,    0,0,0,0));  // reset mid-frame
        tbl.push_back(mk(0,0,1,0,  40,    0,0,0,1));
        tbl.push_back(mk(0,1,0,1,   7,    0,0,1,0));
        tbl.push_back(mk(0,0,1,0,   9,    7,1,0,0));
        tbl.push_back(mk(0,1,0,0,   8,    7,0,1,0));  // back-to-back frame
        tbl.push_back(mk(0,1,1,0, 100,   92,1,0,1));  // go+finish while in RUN

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].g, tbl[i].f, tbl[i].m, tbl[i].d);
            chk("tbl_result", int'(result0), tbl[i].res);
            chk("tbl_valid",  int'(result_valid0), int'(tbl[i].v));
            chk("tbl_busy",   int'(busy0), int'(tbl[i].b));
            chk("tbl_error",  int'(error0), int'(tbl[i].e));
        end

        // COUNT saturation: 20 samples saturate at 15 on WIDTH=4, not on WIDTH=10.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 3, 1);
        for (int i = 0; i < 18; i++) step(0, 0, 0, 0, i);
        step(0, 0, 1, 0, 2);
        chk("sat_w4_count",  int'(result1), 15);
        chk("sat_w10_count", int'(result0), 20);
        // Back-to-back MIN frame starting right after finish.
        step(0, 1, 0, 1, 6);
        step(0, 0, 0, 0, 3);
        step(0, 0, 1, 0, 9);
        chk("b2b_w4_min",  int'(result1), 3);
        chk("b2b_w10_min", int'(result0), 3);
        chk("b2b_valid",   int'(result_valid1), 1);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit r, g, f;
            r = ($urandom_range(0, 99) == 0);
            g = ($urandom_range(0, 9) == 0);
            f = ($urandom_range(0, 11) == 0);
            step(r, g, f, int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/range_stats.md
# range_stats

Parametrised successor to the team's fixed-width range finder. Over a framed stream of unsigned samples, it tracks minimum, maximum, range (max−min) and sample count. One statistic, chosen by a mode latched at frame start, is reported on a registered result port one cycle after the frame ends. Protocol violations raise a sticky error flag. It sits directly behind the chip I/O wrapper: data, `go` and `finish` come from pins, and result and error drive pins.

## Interface
Parameters:
- `WIDTH`, 10, sample and result width in bits (≥2)

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high; clears all state on the edge where it is high
- `data_in`  in  WIDTH  unsigned sample, valid every cycle while a frame is open
- `go`  in  1  frame start; the sample on `data_in` in the same cycle is the first sample
- `finish`  in  1  frame end; the sample on `data_in` in the same cycle is the last sample
- `mode`  in  2  statistic select, latched on an accepted `go`: 0 RANGE, 1 MIN, 2 MAX, 3 COUNT
- `result`  out  WIDTH  selected statistic of the last completed frame
- `result_valid`  out  1  one-cycle pulse when `result` is updated
- `busy`  out  1  high while a frame is open (state RUN)
- `error`  out  1  sticky protocol-error flag

## Operation
- States: IDLE, RUN.
- IDLE, `go`=1 and `finish`=0:
  - min = max = `data_in`; count = 1; latch `mode`; clear `error`; go to RUN.
- IDLE, `go`=1 and `finish`=1:
  - single-sample frame: stats from `data_in`, count = 1, latch `mode`, clear `error`.
  - Produce the result as on a normal finish; stay in IDLE.
- IDLE, `finish`=1 and `go`=0:
  - set `error`; stats and result unchanged; stay in IDLE.
- RUN, each cycle, sample `data_in`:
  - min = min(min, d); max = max(max, d).
  - count += 1, saturating at 2^WIDTH−1.
- RUN, `finish`=1:
  - include this cycle's sample.
  - Load `result` from the updated stats per the latched mode; pulse `result_valid`; go to IDLE.
- RUN, `go`=1:
  - set `error`; `go` is otherwise ignored, and the frame and latched mode are unaffected.
  - If `finish`=1 in the same cycle, the finish still completes the frame, and `error` is still set.
- Result computation:
  - RANGE = max−min, never negative, fits in WIDTH.
  - MIN, MAX are direct.
  - COUNT is the saturated count.
- `error` clears only on reset or on an accepted `go` from IDLE.
  - An error set by a `go` during RUN therefore persists past that frame's result.
- `result` holds its value until the next completed frame. A frame ended by reset produces no result.

## Timing
- Reset values:
  - state IDLE; `result`=0, `result_valid`=0, `busy`=0, `error`=0.
  - min=max=count=0; latched mode RANGE.
- Reset has priority over `go`/`finish` in the same cycle.
- Reset mid-frame discards the frame; no `result_valid`.
- Latency: `finish` sampled at edge N produces `result`/`result_valid` visible after edge N, for one cycle only.
- `busy` rises after the `go` edge and falls after the `finish` edge. It stays low for single-sample frames.
- Back-to-back frames:
  - `go` in the cycle immediately after `finish` is accepted, since state is already IDLE.
  - Min/max restart from that cycle's `data_in`.
- `mode` is ignored except on the accepted-`go` cycle.
- `error` updates on the same edge as the offending `go`/`finish`.

## Structure
- Package `range_stats_pkg`:
  - `mode_t` enum (RANGE, MIN, MAX, COUNT, 2-bit).
  - `state_t` enum (IDLE, RUN).
- One sub-module, `range_stats_acc`:
  - parametrised by WIDTH.
  - holds the min/max/count registers.
  - has `init` (load first sample) and `update` (fold sample) controls.
  - exposes next-state min/max/count combinationally, so the top loads `result` on the finish cycle.
- Top `range_stats`: FSM, mode latch, error flag, result register and mux.

## Test plan
- WIDTH=10, mode RANGE: `go` with 100, then 37, 512, `finish` with 200 → `result`=475 (512−37), `result_valid` one cycle, `busy` high for 3 cycles, `error`=0.
- Same 4-sample stream in each mode MIN/MAX/COUNT (mode changed mid-frame to something else) → `result` = 37 / 512 / 4, i.e. the latched mode wins.
- `go`+`finish` same cycle in IDLE with 1023, mode RANGE → `result`=0, `result_valid` pulses, `busy` stays 0; mode MAX → `result`=1023.
- `finish` in IDLE → `error`=1, no `result_valid`, `result` unchanged. Extra `go` during RUN → `error`=1, frame completes with correct range. Next accepted `go` → `error`=0.
- Reset asserted mid-frame, then `finish` → no `result_valid`, all outputs 0, `error`=1 (finish in IDLE).
- Mode COUNT, WIDTH=4: 20-sample frame → `result`=15 (saturated). Back-to-back frame started the cycle after `finish` → correct independent stats.
